bias_apply_1: RTL and testbench
===============================

# bias_apply_1

Consumer end of the layer-1 bias stream. Drains the `KERN` bias coefficients that the bias producer writes into its ap_fifo, and holds them in a local register bank. It then adds the matching bias to every convolution accumulator arriving on a second ap_fifo stream, rescales and saturates the sum, and writes the result downstream. Biases are reloaded from the stream once per frame, and the producer emits one full bias set per invocation.

## Interface
Parameters:
- `KERN`, 16 (`kern_s_k_1`): output channels, i.e. bias words per set.
- `PIXELS`, 16: output pixels per frame; one bias set is used for `PIXELS*KERN` accumulators.
- `COEFF_W`, 16 (`coeff_width`): bias word width, signed two's complement.
- `ACC_W`, 32: accumulator width, signed.
- `OUT_W`, 16: result width, signed.
- `SHIFT`, 0: arithmetic right shift applied after the bias add, range 0..ACC_W-1.

Ports:
- `ap_clk` in 1: single clock, rising edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `bias_V_dout` in COEFF_W: bias FIFO data.
- `bias_V_empty_n` in 1: bias FIFO has data.
- `bias_V_read` out 1: pop bias FIFO.
- `acc_V_dout` in ACC_W: accumulator FIFO data, channel-interleaved with ch0 first.
- `acc_V_empty_n` in 1: accumulator FIFO has data.
- `acc_V_read` out 1: pop accumulator FIFO.
- `result_V_din` out OUT_W: result data.
- `result_V_full_n` in 1: downstream FIFO has space.
- `result_V_write` out 1: push result.
- `frame_done` out 1: one-cycle pulse when the last result of a frame is written.

## Operation
- FSM has two states, LOAD and RUN. Reset state is LOAD.
- LOAD:
  - `bias_V_read = bias_V_empty_n`.
  - Each pop stores `bias_V_dout` into `bank[ld_idx]` and increments `ld_idx`.
  - Popping word `KERN-1` moves the FSM to RUN and clears `ld_idx`.
  - `acc_V_read` stays 0 throughout LOAD.
- RUN:
  - `bias_V_read` stays 0.
  - Accumulators are accepted when `acc_V_empty_n && (!out_valid || result_V_full_n)`, and `acc_V_read` equals that condition.
  - On accept:
    - `sum = sext(acc, ACC_W+1) + sext(bank[ch], ACC_W+1)`.
    - `shifted = sum >>> SHIFT`.
    - The result saturates to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - The result is registered into `result_V_din` with `out_valid` set.
  - `ch` wraps from KERN-1 to 0. `pix` increments on each `ch` wrap.
  - The accept of pixel `PIXELS-1` at channel `KERN-1` returns the FSM to LOAD and clears `ch` and `pix`.
- Output register:
  - `result_V_write = out_valid`.
  - `out_valid` clears when the write is taken (`full_n = 1`) and no new accept occurs that cycle.
  - When the write and a new accept occur together, the register reloads.
- The final result of a frame may still be waiting in the output register after the FSM enters LOAD. It drains normally, and bias loading for the next frame proceeds in parallel.
- `frame_done` pulses in the cycle the last result of a frame is written (`result_V_write && result_V_full_n` on the flagged word).

## Timing
- Reset values (async, `ap_rst_n = 0`):
  - `out_valid = 0`, `result_V_din = 0`, `frame_done = 0`.
  - `ld_idx`, `ch`, `pix` = 0. FSM = LOAD.
  - Bank contents are don't-care.
- `bias_V_read` and `acc_V_read` are combinational from the FIFO flags and state; there is no registered lookahead.
- Latency: an accumulator popped in cycle N appears on `result_V_din` with `result_V_write = 1` in cycle N+1.
- Throughput: 1 result/cycle in RUN while input is non-empty and output is non-full. Bias load takes 1 word/cycle.
- Backpressure:
  - `full_n = 0` with `out_valid = 1` holds `result_V_din` stable and blocks accepts.
  - No data is lost or duplicated.
- `empty_n = 0` in either state stalls counters. A stall mid-load leaves partial bank contents in place.
- Reset asserted mid-frame discards the output register and forces LOAD. The upstream FIFOs are not flushed by this block.

## Structure
- A shared package (`layers_sizes.vh` / `my_types.vh`) holds `kern_s_k_1`, `coeff_width`, the accumulator and output widths, and the FSM state encoding (`ST_LOAD`, `ST_RUN`).
- One sub-module, `bias_sat_add`: combinational sign-extend, add, shift and saturate, parameterised by `ACC_W`, `COEFF_W`, `OUT_W`, `SHIFT`. It is reused by other layers.
- The bank is a flop array of `KERN x COEFF_W` with one write port and one read port. It is not a ROM/BRAM.

## Test plan
- Basic path: load biases 0..15, then feed `acc = 100` for all channels of one pixel. Results are 100..115 in order, each 1 cycle after its pop.
- Saturation, `OUT_W = 16`:
  - `acc = 32760` with bias 100 gives 32767.
  - `acc = -32760` with bias -100 gives -32768.
  - `SHIFT = 4` with `acc = 1600`, bias 0 gives 100.
- Backpressure: hold `result_V_full_n = 0` for 5 cycles mid-stream. `result_V_din` stays stable, `acc_V_read = 0`, and the sequence is intact after release.
- Frame wrap: run 2 frames with different bias sets.
  - `frame_done` pulses exactly once per frame.
  - Frame 2 uses only the new biases.
  - No accumulator is popped during LOAD.
- Stalls: apply random `empty_n` gaps on both FIFOs during load and run. The output matches the reference model bit-exactly.
- Reset: assert `ap_rst_n = 0` mid-RUN. Outputs go to 0 at once without a clock, and the next operation begins with a bias LOAD.

Source files
------------

// File: rtl/bias_apply_1_pkg.sv
// ---------------------------------------------------------------------------
// bias_apply_1_pkg
// Shared layer-1 sizes, data widths and FSM state encoding for the bias
// consumer and its saturating-add datapath.
// ---------------------------------------------------------------------------
package bias_apply_1_pkg;

   localparam int KERN_S_K_1  = 16;   // output channels / bias words per set
   localparam int PIXELS_1    = 16;   // output pixels per frame
   localparam int COEFF_WIDTH = 16;   // bias word width (signed)
   localparam int ACC_WIDTH   = 32;   // accumulator width (signed)
   localparam int OUT_WIDTH   = 16;   // result width (signed)

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Counter width for an index running 0..n-1; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bias_apply_1_sat.sv
// ---------------------------------------------------------------------------
// bias_sat_add
// Combinational datapath: sign-extend accumulator and bias to ACC_W+1 bits,
// add, arithmetic right shift by SHIFT, then saturate to signed OUT_W.
// Ports:
//   acc_i  [ACC_W-1:0]   signed accumulator
//   bias_i [COEFF_W-1:0] signed bias
//   res_o  [OUT_W-1:0]   saturated signed result
// Assumes COEFF_W <= ACC_W and OUT_W <= ACC_W.
// ---------------------------------------------------------------------------
module bias_sat_add
   import bias_apply_1_pkg::*;
#(
   parameter int ACC_W   = ACC_WIDTH,
   parameter int COEFF_W = COEFF_WIDTH,
   parameter int OUT_W   = OUT_WIDTH,
   parameter int SHIFT   = 0
) (
   input  logic [ACC_W-1:0]   acc_i,
   input  logic [COEFF_W-1:0] bias_i,
   output logic [OUT_W-1:0]   res_o
);

   // Saturation bounds expressed at the full ACC_W+1 sum width.
   localparam logic signed [ACC_W:0] SAT_MAX =
      {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN =
      {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic signed [ACC_W:0] sum_s;
   logic signed [ACC_W:0] shifted_s;

   // One extra bit of headroom makes the add itself overflow-free.
   always_comb begin
      sum_s     = $signed({acc_i[ACC_W-1], acc_i})
                + $signed({{(ACC_W + 1 - COEFF_W){bias_i[COEFF_W-1]}}, bias_i});
      shifted_s = sum_s >>> SHIFT;
   end

   // Clamp the shifted sum into the signed OUT_W range.
   always_comb begin
      if (shifted_s > SAT_MAX) begin
         res_o = SAT_MAX[OUT_W-1:0];
      end else if (shifted_s < SAT_MIN) begin
         res_o = SAT_MIN[OUT_W-1:0];
      end else begin
         res_o = shifted_s[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/bias_apply_1.sv
// ---------------------------------------------------------------------------
// bias_apply_1
// Layer-1 bias consumer. In LOAD it drains KERN bias words from the bias FIFO
// into a flop bank; in RUN it adds bank[ch] to each channel-interleaved
// accumulator, rescales/saturates it and registers the result downstream.
// After PIXELS*KERN accumulators it returns to LOAD for the next bias set.
// Ports:
//   ap_clk, ap_rst_n                          clock, async active-low reset
//   bias_V_dout/_empty_n/_read                bias FIFO read side
//   acc_V_dout/_empty_n/_read                 accumulator FIFO read side
//   result_V_din/_full_n/_write               result FIFO write side
//   frame_done                                pulse when last frame result is written
// ---------------------------------------------------------------------------
module bias_apply_1
   import bias_apply_1_pkg::*;
#(
   parameter int KERN    = KERN_S_K_1,
   parameter int PIXELS  = PIXELS_1,
   parameter int COEFF_W = COEFF_WIDTH,
   parameter int ACC_W   = ACC_WIDTH,
   parameter int OUT_W   = OUT_WIDTH,
   parameter int SHIFT   = 0
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic [COEFF_W-1:0] bias_V_dout,
   input  logic               bias_V_empty_n,
   output logic               bias_V_read,
   input  logic [ACC_W-1:0]   acc_V_dout,
   input  logic               acc_V_empty_n,
   output logic               acc_V_read,
   output logic [OUT_W-1:0]   result_V_din,
   input  logic               result_V_full_n,
   output logic               result_V_write,
   output logic               frame_done
);

   localparam int CH_W  = idx_width(KERN);
   localparam int PIX_W = idx_width(PIXELS);

   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(KERN - 1);
   localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
   localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
   localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
   localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};

   logic [0:0]         state_q, state_d;
   logic [CH_W-1:0]    ld_idx_q, ld_idx_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [PIX_W-1:0]   pix_q, pix_d;
   logic [COEFF_W-1:0] bank_q [KERN];
   logic               out_valid_q;
   logic               last_q;        // output register holds the frame's final result
   logic [OUT_W-1:0]   result_q;

   logic               bias_rd_s;
   logic               acc_rd_s;
   logic               frame_end_s;
   logic [OUT_W-1:0]   sat_s;

   // FIFO pop strobes: combinational from state and flags, no lookahead.
   always_comb begin
      bias_rd_s = 1'b0;
      acc_rd_s  = 1'b0;
      case (state_q)
         ST_LOAD: bias_rd_s = bias_V_empty_n;
         // Accept only if the output register is free or draining this cycle.
         ST_RUN:  acc_rd_s  = acc_V_empty_n & (~out_valid_q | result_V_full_n);
         default: begin
            bias_rd_s = 1'b0;
            acc_rd_s  = 1'b0;
         end
      endcase
   end

   assign frame_end_s = (ch_q == CH_LAST) && (pix_q == PIX_LAST);

   // Next-state for FSM and the load/channel/pixel counters.
   always_comb begin
      state_d  = state_q;
      ld_idx_d = ld_idx_q;
      ch_d     = ch_q;
      pix_d    = pix_q;
      case (state_q)
         ST_LOAD: begin
            if (bias_rd_s) begin
               if (ld_idx_q == CH_LAST) begin
                  ld_idx_d = CH_ZERO;
                  state_d  = ST_RUN;
               end else begin
                  ld_idx_d = ld_idx_q + CH_ONE;
               end
            end else begin
               ld_idx_d = ld_idx_q;
            end
         end
         ST_RUN: begin
            if (acc_rd_s) begin
               if (ch_q == CH_LAST) begin
                  ch_d = CH_ZERO;
                  if (pix_q == PIX_LAST) begin
                     pix_d   = PIX_ZERO;
                     state_d = ST_LOAD;
                  end else begin
                     pix_d = pix_q + PIX_ONE;
                  end
               end else begin
                  ch_d = ch_q + CH_ONE;
               end
            end else begin
               ch_d = ch_q;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // FSM and counter registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q  <= ST_LOAD;
         ld_idx_q <= CH_ZERO;
         ch_q     <= CH_ZERO;
         pix_q    <= PIX_ZERO;
      end else begin
         state_q  <= state_d;
         ld_idx_q <= ld_idx_d;
         ch_q     <= ch_d;
         pix_q    <= pix_d;
      end
   end

   // Bias bank: one write port from the bias FIFO; contents need no reset.
   always_ff @(posedge ap_clk) begin
      if (bias_rd_s) begin
         bank_q[ld_idx_q] <= bias_V_dout;
      end
   end

   bias_sat_add #(
      .ACC_W   (ACC_W),
      .COEFF_W (COEFF_W),
      .OUT_W   (OUT_W),
      .SHIFT   (SHIFT)
   ) u_sat (
      .acc_i  (acc_V_dout),
      .bias_i (bank_q[ch_q]),
      .res_o  (sat_s)
   );

   // Output register: reload on accept, otherwise empty once the write is taken.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
         result_q    <= {OUT_W{1'b0}};
      end else if (acc_rd_s) begin
         out_valid_q <= 1'b1;
         last_q      <= frame_end_s;
         result_q    <= sat_s;
      end else if (out_valid_q && result_V_full_n) begin
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
      end
   end

   assign bias_V_read    = bias_rd_s;
   assign acc_V_read     = acc_rd_s;
   assign result_V_din   = result_q;
   assign result_V_write = out_valid_q;
   assign frame_done     = out_valid_q & last_q & result_V_full_n;

endmodule

// File: tb/tb_bias_apply_1.sv
module tb_bias_apply_1;

   localparam int KERN   = 16;
   localparam int PIXELS = 16;
   localparam int FRAME  = KERN * PIXELS;

   logic        ap_clk;
   logic        ap_rst_n;
   logic [15:0] bias_V_dout;
   logic        bias_V_empty_n;
   logic        bias_V_read;
   logic [31:0] acc_V_dout;
   logic        acc_V_empty_n;
   logic        acc_V_read;
   logic [15:0] result_V_din;
   logic        result_V_full_n;
   logic        result_V_write;
   logic        frame_done;

   logic [31:0] t_acc;
   logic [15:0] t_bias;
   logic [15:0] t_res;

   bias_apply_1 #(
      .KERN(KERN), .PIXELS(PIXELS), .COEFF_W(16), .ACC_W(32), .OUT_W(16), .SHIFT(0)
   ) dut (
      .ap_clk          (ap_clk),
      .ap_rst_n        (ap_rst_n),
      .bias_V_dout     (bias_V_dout),
      .bias_V_empty_n  (bias_V_empty_n),
      .bias_V_read     (bias_V_read),
      .acc_V_dout      (acc_V_dout),
      .acc_V_empty_n   (acc_V_empty_n),
      .acc_V_read      (acc_V_read),
      .result_V_din    (result_V_din),
      .result_V_full_n (result_V_full_n),
      .result_V_write  (result_V_write),
      .frame_done      (frame_done)
   );

   bias_sat_add #(.ACC_W(32), .COEFF_W(16), .OUT_W(16), .SHIFT(4)) u_sat4 (
      .acc_i  (t_acc),
      .bias_i (t_bias),
      .res_o  (t_res)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   typedef struct { int val; bit last; } res_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] bias_fifo[$];
   logic [31:0] acc_fifo[$];
   res_t        pend[$];
   int          got[$];
   int          bset[KERN];
   int          lc = 0;
   int          nacc = 0;
   int          fd_count = 0;
   bit          hold_prev = 0;
   logic [15:0] hold_din;

   task automatic chk(input string name, input longint actual, input longint expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: exact sum, arithmetic shift, clamp to 16-bit signed.
   function automatic int ref_out(input logic [31:0] a, input logic [15:0] b, input int sh);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
      s = s >>> sh;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return int'(s);
   endfunction

   function automatic logic [31:0] rand_acc();
      int r;
      if ($urandom_range(0, 3) == 0) return 32'($urandom);
      r = int'($urandom_range(0, 80000)) - 40000;
      return 32'(r);
   endfunction

   // kind 0: biases 0..15, pixel 0 all 100; kind 1: saturation set; else random.
   task automatic push_frame(input int kind);
      for (int k = 0; k < KERN; k++) begin
         if (kind == 0) bias_fifo.push_back(16'(k));
         else if (kind == 1 && k == 0) bias_fifo.push_back(16'sd100);
         else if (kind == 1 && k == 1) bias_fifo.push_back(-16'sd100);
         else bias_fifo.push_back(16'($urandom));
      end
      for (int n = 0; n < FRAME; n++) begin
         if (kind == 0 && n < KERN) acc_fifo.push_back(32'd100);
         else if (kind == 1 && n == 0) acc_fifo.push_back(32'sd32760);
         else if (kind == 1 && n == 1) acc_fifo.push_back(-32'sd32760);
         else acc_fifo.push_back(rand_acc());
      end
   endtask

   task automatic run(input int gap, input int bp_at, input int stop_after);
      int  written = 0;
      int  bp_left = 0;
      bit  done = 0;
      bit  e_brd, e_ard, e_wr, e_fd;
      res_t r;
      for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
         @(negedge ap_clk);
         if (bp_at >= 0 && written == bp_at && bp_left == 0) begin
            bp_left = 5;
            bp_at   = -1;
         end
         bias_V_empty_n  = (bias_fifo.size() > 0) && ($urandom_range(0, 99) >= gap);
         bias_V_dout     = (bias_fifo.size() > 0) ? bias_fifo[0] : 16'h0000;
         acc_V_empty_n   = (acc_fifo.size() > 0) && ($urandom_range(0, 99) >= gap);
         acc_V_dout      = (acc_fifo.size() > 0) ? acc_fifo[0] : 32'h0;
         result_V_full_n = (bp_left > 0) ? 1'b0 : ($urandom_range(0, 99) >= gap / 2);
         if (bp_left > 0) bp_left--;
         #1;
         e_brd = (lc < KERN) && bias_V_empty_n;
         e_ard = (lc == KERN) && acc_V_empty_n && (pend.size() == 0 || result_V_full_n);
         e_wr  = pend.size() > 0;
         e_fd  = e_wr && result_V_full_n && pend[0].last;
         chk("bias_read", bias_V_read, e_brd);
         chk("acc_read", acc_V_read, e_ard);
         chk("result_write", result_V_write, e_wr);
         chk("frame_done", frame_done, e_fd);
         if (e_wr) chk("result_data", $signed(result_V_din), pend[0].val);
         if (hold_prev) chk("hold_stable", result_V_din, hold_din);
         hold_prev = result_V_write && !result_V_full_n;
         hold_din  = result_V_din;
         if (frame_done) fd_count++;
         if (e_wr && result_V_full_n) begin
            r = pend.pop_front();
            got.push_back(r.val);
            written++;
         end
         if (e_brd) begin
            bset[lc] = int'(bias_fifo.pop_front());
            lc++;
         end
         if (e_ard) begin
            r.val  = ref_out(acc_fifo.pop_front(), 16'(bset[nacc % KERN]), 0);
            r.last = (nacc == FRAME - 1);
            pend.push_back(r);
            nacc++;
            if (nacc == FRAME) begin
               nacc = 0;
               lc   = 0;
            end
         end
         if (stop_after > 0 && written >= stop_after) done = 1;
         if (bias_fifo.size() == 0 && acc_fifo.size() == 0 && pend.size() == 0) done = 1;
      end
      if (!done) chk("run_timeout", 0, 1);
   endtask

   initial begin
      ap_rst_n        = 1'b0;
      bias_V_dout     = 16'h0000;
      bias_V_empty_n  = 1'b0;
      acc_V_dout      = 32'h0;
      acc_V_empty_n   = 1'b0;
      result_V_full_n = 1'b1;
      t_acc           = 32'd1600;
      t_bias          = 16'd0;
      #1;
      chk("rst_write", result_V_write, 0);
      chk("rst_din", result_V_din, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_acc_read", acc_V_read, 0);
      chk("shift4_1600", $signed(t_res), 100);
      for (int i = 0; i < 4; i++) begin
         t_acc  = rand_acc();
         t_bias = 16'($urandom);
         #1;
         chk("shift4_rand", $signed(t_res), ref_out(t_acc, t_bias, 4));
      end
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;

      // Two frames back to back, no gaps, one 5-cycle backpressure window.
      push_frame(0);
      push_frame(1);
      run(0, 40, 0);
      for (int k = 0; k < KERN; k++) chk("basic_path", got[k], 100 + k);
      chk("sat_pos", got[FRAME], 32767);
      chk("sat_neg", got[FRAME + 1], -32768);
      chk("frame_done_2", fd_count, 2);

      // Random gaps on both FIFOs and on the output.
      push_frame(2);
      run(30, -1, 0);
      chk("frame_done_3", fd_count, 3);

      // Reset mid-RUN.
      push_frame(2);
      run(20, -1, 50);
      acc_V_empty_n = 1'b1;
      #2;
      ap_rst_n = 1'b0;
      #1;
      chk("midrst_write", result_V_write, 0);
      chk("midrst_din", result_V_din, 0);
      chk("midrst_frame_done", frame_done, 0);
      chk("midrst_acc_read", acc_V_read, 0);
      bias_V_empty_n = 1'b0;
      acc_V_empty_n  = 1'b0;
      bias_fifo.delete();
      acc_fifo.delete();
      pend.delete();
      lc        = 0;
      nacc      = 0;
      hold_prev = 0;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;

      // Fresh frame after reset must start with a bias load.
      push_frame(2);
      run(25, 100, 0);
      chk("frame_done_4", fd_count, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
